fdtd_sweep_sched: RTL and testbench

FDTD_SWEEP_SCHED -- requirements
Module: fdtd_sweep_sched

---
 rtl/fdtd_pkg.sv | 15 +
 rtl/fdtd_valid_pipe.sv | 40 ++++
 rtl/fdtd_sweep_sched.sv | 158 +++++++++++++++
 tb/tb_fdtd_sweep_sched.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fdtd_pkg.sv
// Shared types and defaults for the FDTD sweep scheduler.
// Holds the sweep state encoding and the default datapath latency.
package fdtd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        GAP,
        DONE
    } state_t;

    localparam int PIPE_LAT_DEFAULT = 2;

endpackage

// File: rtl/fdtd_valid_pipe.sv
// Valid-bit shift register that mirrors the update datapath latency.
// It advances only on enabled cycles, so stalls freeze in-flight cells in place.
module fdtd_valid_pipe
    import fdtd_pkg::*;
#(
    parameter int PIPE_LAT = PIPE_LAT_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ce,
    input  logic valid_i,
    output logic valid_o,
    output logic any_o
);

    logic [PIPE_LAT-1:0] vld_q;
    logic [PIPE_LAT-1:0] vld_d;

    always_comb begin
        vld_d = vld_q;
        if (ce) begin
            vld_d[0] = valid_i;
            for (int i = 1; i < PIPE_LAT; i++) begin
                vld_d[i] = vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    assign valid_o = vld_q[PIPE_LAT-1];
    assign any_o   = |vld_q;

endmodule

// File: rtl/fdtd_sweep_sched.sv
// Sweep scheduler: issues per-cell reads, tracks the update pipeline and emits writes, step by step.
// Optional stall counter output stall_cnt_o is built when FDTD_SWEEP_PERF_EN is defined.
module fdtd_sweep_sched
    import fdtd_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int STEP_WIDTH = 16,
    parameter int PIPE_LAT   = PIPE_LAT_DEFAULT
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic                  stall_i,
    input  logic [ADDR_WIDTH-1:0] cell_num_i,
    input  logic [STEP_WIDTH-1:0] step_num_i,
    input  logic [ADDR_WIDTH-1:0] rd_base_i,
    input  logic [ADDR_WIDTH-1:0] wr_base_i,
    output logic                  rd_en_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic                  pipe_ce_o,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [STEP_WIDTH-1:0] step_o
`ifdef FDTD_SWEEP_PERF_EN
    ,
    output logic [31:0]           stall_cnt_o
`endif
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] wcnt_q, wcnt_d;
    logic [STEP_WIDTH-1:0] step_q, step_d;
    logic [ADDR_WIDTH-1:0] cells_q, rdBase_q, wrBase_q;
    logic [STEP_WIDTH-1:0] steps_q;

    logic active, pipeCe, rdEn, wrEn, busy, done;
    logic validLast, anyValid, abortHit, acceptStart;

    assign active      = (state_q == ISSUE) || (state_q == DRAIN) || (state_q == GAP);
    assign pipeCe      = active & ~stall_i;
    assign wrEn        = validLast & pipeCe;
    assign abortHit    = abort_i & (state_q != IDLE);
    assign acceptStart = (state_q == IDLE) & start_i & ~abort_i;

    // Abort aborts the whole sweep; the valid pipe is flushed along with it.
    fdtd_valid_pipe #(
        .PIPE_LAT (PIPE_LAT)
    ) u_valid_pipe (
        .clk_i   (CLK),
        .rst_i   (RST | abortHit),
        .ce      (pipeCe),
        .valid_i (rdEn),
        .valid_o (validLast),
        .any_o   (anyValid)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wcnt_d  = wrEn ? wcnt_q + ADDR_WIDTH'(1) : wcnt_q;
        step_d  = step_q;
        rdEn    = 1'b0;
        busy    = (state_q != IDLE);
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (acceptStart) begin
                    idx_d   = '0;
                    wcnt_d  = '0;
                    step_d  = '0;
                    state_d = ((cell_num_i == '0) || (step_num_i == '0)) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (!stall_i) begin
                    rdEn  = 1'b1;
                    idx_d = idx_q + ADDR_WIDTH'(1);
                    if (idx_q == cells_q - ADDR_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The registered write count reaches cell_num one cycle after the last write.
                if ((wcnt_q == cells_q) && !anyValid) begin
                    state_d = (step_q < steps_q - STEP_WIDTH'(1)) ? GAP : DONE;
                end
            end
            GAP: begin
                step_d  = step_q + STEP_WIDTH'(1);
                idx_d   = '0;
                wcnt_d  = '0;
                state_d = ISSUE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abortHit) begin
            state_d = IDLE;
            done    = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            wcnt_q   <= '0;
            step_q   <= '0;
            cells_q  <= '0;
            steps_q  <= '0;
            rdBase_q <= '0;
            wrBase_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wcnt_q  <= wcnt_d;
            step_q  <= step_d;
            if (acceptStart) begin
                cells_q  <= cell_num_i;
                steps_q  <= step_num_i;
                rdBase_q <= rd_base_i;
                wrBase_q <= wr_base_i;
            end
        end
    end

`ifdef FDTD_SWEEP_PERF_EN
    logic [31:0] stallCnt_q;

    always_ff @(posedge CLK) begin
        if (RST || acceptStart) begin
            stallCnt_q <= '0;
        end else if (busy && stall_i && (stallCnt_q != '1)) begin
            stallCnt_q <= stallCnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stallCnt_q;
`endif

    assign rd_en_o   = rdEn;
    assign rd_addr_o = rdBase_q + idx_q;
    assign pipe_ce_o = pipeCe;
    assign wr_en_o   = wrEn;
    assign wr_addr_o = wrBase_q + wcnt_q;
    assign busy_o    = busy;
    assign done_o    = done;
    assign step_o    = step_q;

endmodule

// File: tb/tb_fdtd_sweep_sched.sv
// Self-checking bench for fdtd_sweep_sched: directed and randomized sweeps against a timeline model.
// The model derives every read/write/done cycle from the stall pattern with plain arithmetic.
module tb_fdtd_sweep_sched;

    localparam int AW   = 10;
    localparam int SW   = 16;
    localparam int L    = 2;
    localparam int MAXC = 256;

    logic          CLK = 1'b0;
    logic          RST;
    logic          start_i, abort_i, stall_i;
    logic [AW-1:0] cell_num_i, rd_base_i, wr_base_i;
    logic [SW-1:0] step_num_i;
    logic          rd_en_o, pipe_ce_o, wr_en_o, busy_o, done_o;
    logic [AW-1:0] rd_addr_o, wr_addr_o;
    logic [SW-1:0] step_o;
`ifdef FDTD_SWEEP_PERF_EN
    logic [31:0]   stall_cnt_o;
`endif

    int nChecks = 0;
    int nFails  = 0;

    bit            stallVec  [MAXC];
    bit            expRd     [MAXC];
    bit            expWr     [MAXC];
    logic [AW-1:0] expRdAddr [MAXC];
    logic [AW-1:0] expWrAddr [MAXC];
    int            expStep   [MAXC];

    fdtd_sweep_sched #(
        .ADDR_WIDTH (AW),
        .STEP_WIDTH (SW),
        .PIPE_LAT   (L)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .start_i    (start_i),
        .abort_i    (abort_i),
        .stall_i    (stall_i),
        .cell_num_i (cell_num_i),
        .step_num_i (step_num_i),
        .rd_base_i  (rd_base_i),
        .wr_base_i  (wr_base_i),
        .rd_en_o    (rd_en_o),
        .rd_addr_o  (rd_addr_o),
        .pipe_ce_o  (pipe_ce_o),
        .wr_en_o    (wr_en_o),
        .wr_addr_o  (wr_addr_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .step_o     (step_o)
`ifdef FDTD_SWEEP_PERF_EN
        ,
        .stall_cnt_o (stall_cnt_o)
`endif
    );

    always #5 CLK = ~CLK;

    // Cycle 0 is the start cycle; each read lands on the k-th unstalled issue cycle of its step,
    // and its write lands on the L-th unstalled cycle after it. A step ends one cycle after its
    // last write, followed by a one-cycle gap (or the done cycle on the final step).
    task automatic buildModel(input int C, input int S, input logic [AW-1:0] rdb,
                              input logic [AW-1:0] wrb, output int doneT);
        int t, u, cnt, lastW;
        for (int i = 0; i < MAXC; i++) begin
            expRd[i] = 0; expWr[i] = 0; expRdAddr[i] = '0; expWrAddr[i] = '0; expStep[i] = 0;
        end
        t = 1; lastW = 0; doneT = 0;
        for (int s = 0; s < S; s++) begin
            for (int k = 0; k < C; k++) begin
                while (stallVec[t] && t < MAXC - 8) begin
                    expStep[t] = s;
                    t++;
                end
                expRd[t] = 1;
                expRdAddr[t] = AW'(int'(rdb) + s * 0 + k);
                expStep[t] = s;
                u = t; cnt = 0;
                while (cnt < L && u < MAXC - 8) begin
                    u++;
                    if (!stallVec[u]) cnt++;
                end
                expWr[u] = 1;
                expWrAddr[u] = AW'(int'(wrb) + k);
                lastW = u;
                t++;
            end
            for (int x = t; x <= lastW + 2; x++) expStep[x] = s;
            if (s < S - 1) t = lastW + 3;
            else doneT = lastW + 2;
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
            start_i = 0; abort_i = 0; stall_i = 0;
        end
    endtask

    task automatic test_reset();
        @(posedge CLK); #1;
        RST = 1; start_i = 0; abort_i = 0; stall_i = 0;
        cell_num_i = '0; step_num_i = '0; rd_base_i = '0; wr_base_i = '0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 0;
        @(negedge CLK);
        nChecks += 8;
        if (rd_en_o   !== 1'b0) begin nFails++; $display("[TB] FAIL reset rd_en_o got %b want 0", rd_en_o); end
        if (rd_addr_o !== '0)   begin nFails++; $display("[TB] FAIL reset rd_addr_o got %h want 0", rd_addr_o); end
        if (pipe_ce_o !== 1'b0) begin nFails++; $display("[TB] FAIL reset pipe_ce_o got %b want 0", pipe_ce_o); end
        if (wr_en_o   !== 1'b0) begin nFails++; $display("[TB] FAIL reset wr_en_o got %b want 0", wr_en_o); end
        if (wr_addr_o !== '0)   begin nFails++; $display("[TB] FAIL reset wr_addr_o got %h want 0", wr_addr_o); end
        if (busy_o    !== 1'b0) begin nFails++; $display("[TB] FAIL reset busy_o got %b want 0", busy_o); end
        if (done_o    !== 1'b0) begin nFails++; $display("[TB] FAIL reset done_o got %b want 0", done_o); end
        if (step_o    !== '0)   begin nFails++; $display("[TB] FAIL reset step_o got %0d want 0", step_o); end
    endtask

    // Scenarios 0-3 are the directed sweeps (basic, single stall, two steps, read wrap);
    // the rest are random. A junk start with junk configuration is pulsed mid-run.
    task automatic test_sweeps();
        int C, S, doneT;
        logic [AW-1:0] rdb, wrb;
        bit expCe, expB;
        for (int sc = 0; sc < 10; sc++) begin
            for (int i = 0; i < MAXC; i++) stallVec[i] = 0;
            case (sc)
                0: begin C = 4; S = 1; rdb = 10'h010; wrb = 10'h200; end
                1: begin C = 4; S = 1; rdb = 10'h010; wrb = 10'h200; stallVec[2] = 1; end
                2: begin C = 3; S = 2; rdb = 10'h040; wrb = 10'h300; end
                3: begin C = 4; S = 1; rdb = 10'h3FE; wrb = 10'h3FD; end
                default: begin
                    C = $urandom_range(1, 10); S = $urandom_range(1, 3);
                    rdb = AW'($urandom); wrb = AW'($urandom);
                    for (int i = 1; i < MAXC; i++) stallVec[i] = ($urandom_range(0, 3) == 0);
                end
            endcase
            buildModel(C, S, rdb, wrb, doneT);
            @(posedge CLK); #1;
            start_i = 1; cell_num_i = AW'(C); step_num_i = SW'(S);
            rd_base_i = rdb; wr_base_i = wrb; stall_i = 0;
            for (int t = 1; t <= doneT + 2; t++) begin
                @(posedge CLK); #1;
                start_i = (t == 2);
                if (t == 2) begin
                    cell_num_i = AW'($urandom); step_num_i = SW'($urandom);
                    rd_base_i = AW'($urandom); wr_base_i = AW'($urandom);
                end
                stall_i = stallVec[t];
                @(negedge CLK);
                expB  = (t <= doneT);
                expCe = (t < doneT) && !stallVec[t];
                nChecks += 5;
                if (rd_en_o !== expRd[t]) begin nFails++;
                    $display("[TB] FAIL sweep%0d rd_en_o cycle %0d got %b want %b", sc, t, rd_en_o, expRd[t]); end
                if (wr_en_o !== expWr[t]) begin nFails++;
                    $display("[TB] FAIL sweep%0d wr_en_o cycle %0d got %b want %b", sc, t, wr_en_o, expWr[t]); end
                if (done_o !== (t == doneT)) begin nFails++;
                    $display("[TB] FAIL sweep%0d done_o cycle %0d got %b want %b", sc, t, done_o, (t == doneT)); end
                if (busy_o !== expB) begin nFails++;
                    $display("[TB] FAIL sweep%0d busy_o cycle %0d got %b want %b", sc, t, busy_o, expB); end
                if (pipe_ce_o !== expCe) begin nFails++;
                    $display("[TB] FAIL sweep%0d pipe_ce_o cycle %0d got %b want %b", sc, t, pipe_ce_o, expCe); end
                if (expRd[t]) begin
                    nChecks++;
                    if (rd_addr_o !== expRdAddr[t]) begin nFails++;
                        $display("[TB] FAIL sweep%0d rd_addr_o cycle %0d got %h want %h", sc, t, rd_addr_o, expRdAddr[t]); end
                end
                if (expWr[t]) begin
                    nChecks++;
                    if (wr_addr_o !== expWrAddr[t]) begin nFails++;
                        $display("[TB] FAIL sweep%0d wr_addr_o cycle %0d got %h want %h", sc, t, wr_addr_o, expWrAddr[t]); end
                end
                if (t <= doneT) begin
                    nChecks++;
                    if (int'(step_o) !== expStep[t]) begin nFails++;
                        $display("[TB] FAIL sweep%0d step_o cycle %0d got %0d want %0d", sc, t, step_o, expStep[t]); end
                end
            end
            idleCycles(1);
        end
    endtask

    task automatic test_abort();
        // Abort in the second drain cycle of a 4-cell single-step sweep.
        @(posedge CLK); #1;
        start_i = 1; cell_num_i = 10'd4; step_num_i = 16'd1; rd_base_i = 10'h010; wr_base_i = 10'h200;
        for (int t = 1; t <= 14; t++) begin
            @(posedge CLK); #1;
            start_i = 0; abort_i = (t == 6);
            @(negedge CLK);
            if (t == 7) begin
                nChecks++;
                if (busy_o !== 1'b0) begin nFails++; $display("[TB] FAIL abort_idle busy_o got %b want 0", busy_o); end
            end
            if (t >= 7) begin
                nChecks += 2;
                if (wr_en_o !== 1'b0) begin nFails++; $display("[TB] FAIL abort_nowrite cycle %0d wr_en_o got %b want 0", t, wr_en_o); end
                if (done_o !== 1'b0)  begin nFails++; $display("[TB] FAIL abort_nodone cycle %0d done_o got %b want 0", t, done_o); end
            end
        end
        // Abort and start together mid-run: abort wins and the start is not taken.
        @(posedge CLK); #1;
        abort_i = 0; start_i = 1; cell_num_i = 10'd6;
        for (int t = 1; t <= 6; t++) begin
            @(posedge CLK); #1;
            start_i = (t == 2); abort_i = (t == 2); cell_num_i = 10'd2;
            @(negedge CLK);
            if (t >= 3) begin
                nChecks += 3;
                if (busy_o !== 1'b0)  begin nFails++; $display("[TB] FAIL abort_start busy_o cycle %0d got %b want 0", t, busy_o); end
                if (rd_en_o !== 1'b0) begin nFails++; $display("[TB] FAIL abort_start rd_en_o cycle %0d got %b want 0", t, rd_en_o); end
                if (done_o !== 1'b0)  begin nFails++; $display("[TB] FAIL abort_start done_o cycle %0d got %b want 0", t, done_o); end
            end
        end
        // Abort and start together in idle: nothing starts.
        @(posedge CLK); #1;
        start_i = 1; abort_i = 1;
        @(posedge CLK); #1;
        start_i = 0; abort_i = 0;
        @(negedge CLK);
        nChecks++;
        if (busy_o !== 1'b0) begin nFails++; $display("[TB] FAIL abort_start_idle busy_o got %b want 0", busy_o); end
        idleCycles(1);
    endtask

    task automatic test_zero();
        for (int z = 0; z < 2; z++) begin
            @(posedge CLK); #1;
            start_i = 1; abort_i = 0; stall_i = 0;
            cell_num_i = (z == 0) ? 10'd0 : 10'd5;
            step_num_i = (z == 0) ? 16'd3 : 16'd0;
            for (int t = 1; t <= 3; t++) begin
                @(posedge CLK); #1;
                start_i = 0;
                @(negedge CLK);
                nChecks += 3;
                if (done_o !== (t == 1)) begin nFails++; $display("[TB] FAIL zero%0d done_o cycle %0d got %b want %b", z, t, done_o, (t == 1)); end
                if (busy_o !== (t == 1)) begin nFails++; $display("[TB] FAIL zero%0d busy_o cycle %0d got %b want %b", z, t, busy_o, (t == 1)); end
                if (rd_en_o !== 1'b0)    begin nFails++; $display("[TB] FAIL zero%0d rd_en_o cycle %0d got %b want 0", z, t, rd_en_o); end
            end
        end
    endtask

    task automatic test_reset_midrun();
        int nRd, nWr, nDone;
        @(posedge CLK); #1;
        start_i = 1; cell_num_i = 10'd8; step_num_i = 16'd2; rd_base_i = 10'h055; wr_base_i = 10'h155;
        for (int t = 1; t <= 4; t++) begin
            @(posedge CLK); #1;
            start_i = 0; RST = (t == 3);
        end
        @(negedge CLK);
        nChecks += 6;
        if (rd_en_o !== 1'b0 || rd_addr_o !== '0) begin nFails++; $display("[TB] FAIL midreset rd got %b/%h want 0/0", rd_en_o, rd_addr_o); end
        if (wr_en_o !== 1'b0 || wr_addr_o !== '0) begin nFails++; $display("[TB] FAIL midreset wr got %b/%h want 0/0", wr_en_o, wr_addr_o); end
        if (pipe_ce_o !== 1'b0) begin nFails++; $display("[TB] FAIL midreset pipe_ce_o got %b want 0", pipe_ce_o); end
        if (busy_o !== 1'b0)    begin nFails++; $display("[TB] FAIL midreset busy_o got %b want 0", busy_o); end
        if (done_o !== 1'b0)    begin nFails++; $display("[TB] FAIL midreset done_o got %b want 0", done_o); end
        if (step_o !== '0)      begin nFails++; $display("[TB] FAIL midreset step_o got %0d want 0", step_o); end
        @(posedge CLK); #1;
        start_i = 1; cell_num_i = 10'd2; step_num_i = 16'd1; rd_base_i = 10'h020; wr_base_i = 10'h120;
        nRd = 0; nWr = 0; nDone = 0;
        for (int t = 1; t <= 20; t++) begin
            @(posedge CLK); #1;
            start_i = 0;
            @(negedge CLK);
            if (t == 1) begin
                nChecks++;
                if (rd_en_o !== 1'b1 || rd_addr_o !== 10'h020) begin nFails++;
                    $display("[TB] FAIL restart first read got %b/%h want 1/020", rd_en_o, rd_addr_o); end
            end
            if (rd_en_o) nRd++;
            if (wr_en_o) nWr++;
            if (done_o) nDone++;
        end
        nChecks += 3;
        if (nRd != 2)   begin nFails++; $display("[TB] FAIL restart read count got %0d want 2", nRd); end
        if (nWr != 2)   begin nFails++; $display("[TB] FAIL restart write count got %0d want 2", nWr); end
        if (nDone != 1) begin nFails++; $display("[TB] FAIL restart done count got %0d want 1", nDone); end
    endtask

    initial begin
        RST = 1; start_i = 0; abort_i = 0; stall_i = 0;
        cell_num_i = '0; step_num_i = '0; rd_base_i = '0; wr_base_i = '0;
        test_reset();
        test_sweeps();
        test_abort();
        test_zero();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
